// File: rtl/multicycle_datapath.sv
// Datapath of the multicycle MIPS core: PC, IR, MDR, A, B, ALUOut, a 32-entry
// register file and the ALU, all steered cycle by cycle by an external controller.
module multicycle_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCEn,
  input  logic             IorD,
  input  logic             Memwrite,
  input  logic             IRWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             ALUsrcA,
  input  logic             PCsrc,
  input  logic [1:0]       ALUsrcB,
  input  logic [2:0]       ALUControl,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             zero,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, a_q, b_q, aluout_q;
  logic [WIDTH-1:0] rf_q [32];

  logic [4:0]       rs_idx, rt_idx, rd_idx, wr_idx;
  logic [WIDTH-1:0] rs_val, rt_val, wr_data;
  logic [WIDTH-1:0] imm_sext, src_a, src_b, alu_result;

  assign rs_idx = ir_q[25:21];
  assign rt_idx = ir_q[20:16];
  assign rd_idx = ir_q[15:11];

  // Register 0 is hardwired to zero on the read side; writes to it are dropped below.
  assign rs_val = (rs_idx == 5'd0) ? '0 : rf_q[rs_idx];
  assign rt_val = (rt_idx == 5'd0) ? '0 : rf_q[rt_idx];

  assign wr_idx  = RegDst ? rd_idx : rt_idx;
  assign wr_data = MemtoReg ? mdr_q : aluout_q;

  assign imm_sext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign src_a    = ALUsrcA ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    case (ALUsrcB)
      2'd0:    src_b = b_q;
      2'd1:    src_b = WIDTH'(4);
      2'd2:    src_b = imm_sext;
      default: src_b = {imm_sext[WIDTH-3:0], 2'b00};
    endcase
  end

  // Unused ALU codes deliberately yield zero so they are harmless if issued.
  always_comb begin
    alu_result = '0;
    case (ALUControl)
      3'd0:    alu_result = src_a & src_b;
      3'd1:    alu_result = src_a | src_b;
      3'd2:    alu_result = src_a + src_b;
      3'd6:    alu_result = src_a - src_b;
      3'd7:    alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (PCEn) pc_d = PCsrc ? aluout_q : alu_result;
    ir_d = IRWrite ? mem_rdata : ir_q;
  end

  // A/B sample the pre-write register contents when a write lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mem_rdata;
      a_q      <= rs_val;
      b_q      <= rt_val;
      aluout_q <= alu_result;
      if (RegWrite && (wr_idx != 5'd0)) rf_q[wr_idx] <= wr_data;
    end
  end

  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign zero      = (alu_result == '0);
  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_we    = Memwrite;
  assign pc        = pc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: drives controller-style control words on the
// falling edge and compares against an instruction-level architectural model.
module tb_multicycle_datapath;

  logic        clk, rst;
  logic        PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc;
  logic [1:0]  ALUsrcB;
  logic [2:0]  ALUControl;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_we;

  typedef struct packed {
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcsrc;
    logic [1:0] alusrcb;
    logic [2:0] aluctl;
  } ctrl_t;

  logic [31:0] mem [4096];
  logic [31:0] rf_m [32];
  logic [31:0] pc_m;
  logic [31:0] exp_q [$];
  int checks   = 0;
  int failures = 0;

  assign mem_rdata = mem[mem_addr[13:2]];

  multicycle_datapath #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .PCEn(PCEn), .IorD(IorD), .Memwrite(Memwrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUsrcA(ALUsrcA), .PCsrc(PCsrc), .ALUsrcB(ALUsrcB), .ALUControl(ALUControl),
    .opcode(opcode), .funct(funct), .zero(zero),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .pc(pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model helpers
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd6:    return a - b;
      3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [5:0] funct_of(input logic [2:0] op);
    case (op)
      3'd0:    return 6'h24;
      3'd1:    return 6'h25;
      3'd2:    return 6'h20;
      3'd6:    return 6'h22;
      3'd7:    return 6'h2a;
      default: return {3'b000, op};
    endcase
  endfunction

  function automatic ctrl_t c_idle();
    ctrl_t c = '0;
    return c;
  endfunction

  function automatic ctrl_t c_fetch();
    ctrl_t c = '0;
    c.pcen = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'd1; c.aluctl = 3'd2;
    return c;
  endfunction

  function automatic ctrl_t c_decode();
    ctrl_t c = '0;
    c.alusrcb = 2'd3; c.aluctl = 3'd2;
    return c;
  endfunction

  function automatic ctrl_t c_exec(input logic [1:0] srcb, input logic [2:0] op);
    ctrl_t c = '0;
    c.alusrca = 1'b1; c.alusrcb = srcb; c.aluctl = op;
    return c;
  endfunction

  function automatic ctrl_t c_wb(input logic regdst, input logic memtoreg);
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.regdst = regdst; c.memtoreg = memtoreg;
    return c;
  endfunction

  function automatic ctrl_t c_mem();
    ctrl_t c = '0;
    c.iord = 1'b1;
    return c;
  endfunction

  // driver tasks
  task automatic drive(input ctrl_t c);
    PCEn = c.pcen; IorD = c.iord; Memwrite = c.memwrite; IRWrite = c.irwrite;
    RegDst = c.regdst; MemtoReg = c.memtoreg; RegWrite = c.regwrite;
    ALUsrcA = c.alusrca; PCsrc = c.pcsrc; ALUsrcB = c.alusrcb; ALUControl = c.aluctl;
  endtask

  task automatic apply(input ctrl_t c);
    @(negedge clk);
    drive(c);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input ctrl_t c);
    apply(c);
    tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
    pc_m = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(c_idle());
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fetch_word(input logic [31:0] w);
    mem[pc_m[13:2]] = w;
    cycle(c_fetch());
    pc_m = pc_m + 32'd4;
  endtask

  // Loads IR with a word whose rs/rt name the register, then lets B capture it.
  task automatic probe(input logic [4:0] r, input logic [31:0] exp);
    ctrl_t c;
    c = '0;
    c.irwrite = 1'b1;
    mem[pc_m[13:2]] = {6'h00, r, r, 16'h0000};
    cycle(c);
    cycle(c_idle());
    checks++;
    if (mem_wdata !== exp)
      $display("FAIL probe_rf[%0d]: got %h expected %h", r, mem_wdata, exp);
    if (mem_wdata !== exp) failures++;
    checks++;
    if (pc !== pc_m) begin
      failures++;
      $display("FAIL probe_pc: got %h expected %h", pc, pc_m);
    end
  endtask

  task automatic run_addi(input logic [4:0] rt, input logic [15:0] imm);
    fetch_word({6'h08, 5'd0, rt, imm});
    cycle(c_decode());
    cycle(c_exec(2'd2, 3'd2));
    cycle(c_wb(1'b0, 1'b0));
    if (rt != 5'd0) rf_m[rt] = sext16(imm);
  endtask

  task automatic run_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] op);
    logic [31:0] res;
    res = alu_ref(op, rf_m[rs], rf_m[rt]);
    fetch_word({6'h00, rs, rt, rd, 5'd0, funct_of(op)});
    cycle(c_decode());
    cycle(c_exec(2'd0, op));
    cycle(c_wb(1'b1, 1'b0));
    if (rd != 5'd0) rf_m[rd] = res;
  endtask

  task automatic run_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] addr;
    addr = rf_m[rs] + sext16(imm);
    fetch_word({6'h23, rs, rt, imm});
    cycle(c_decode());
    cycle(c_exec(2'd2, 3'd2));
    apply(c_mem());
    checks++;
    if (mem_addr !== addr) begin
      failures++;
      $display("FAIL lw_mem_addr: got %h expected %h", mem_addr, addr);
    end
    tick();
    cycle(c_wb(1'b0, 1'b1));
    if (rt != 5'd0) rf_m[rt] = mem[addr[13:2]];
  endtask

  // test tasks
  task automatic test_reset();
    rst = 1'b1;
    drive(c_idle());
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", pc); end
    checks++;
    if (opcode !== 6'h0) begin failures++; $display("FAIL reset_opcode: got %h expected 0", opcode); end
    checks++;
    if (funct !== 6'h0) begin failures++; $display("FAIL reset_funct: got %h expected 0", funct); end
    checks++;
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_b: got %h expected 0", mem_wdata); end
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero: got %b expected 1", zero); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fetch();
    fetch_word(32'h8C220004);
    checks++;
    if (opcode !== 6'h23) begin failures++; $display("FAIL fetch_opcode: got %h expected 23", opcode); end
    checks++;
    if (funct !== 6'h04) begin failures++; $display("FAIL fetch_funct: got %h expected 04", funct); end
    checks++;
    if (pc !== 32'h4) begin failures++; $display("FAIL fetch_pc: got %h expected 4", pc); end
    for (int r = 0; r < 32; r++) probe(5'(r), 32'h0);
  endtask

  task automatic test_rtype();
    do_reset();
    run_addi(5'd1, 16'd5);
    run_addi(5'd2, 16'd7);
    run_rtype(5'd1, 5'd2, 5'd3, 3'd2);
    probe(5'd3, 32'd12);
    run_rtype(5'd1, 5'd2, 5'd3, 3'd6);
    probe(5'd3, 32'hFFFFFFFE);
    probe(5'd1, rf_m[1]);
  endtask

  task automatic test_lw();
    do_reset();
    run_addi(5'd1, 16'h0010);
    mem[32'h14 >> 2] = 32'hDEADBEEF;
    run_lw(5'd1, 5'd2, 16'h0004);
    probe(5'd2, 32'hDEADBEEF);
  endtask

  task automatic test_reg0();
    logic [31:0] instr, old_val, exp;
    do_reset();
    run_addi(5'd1, 16'd4);
    run_addi(5'd2, 16'd5);
    run_rtype(5'd1, 5'd2, 5'd0, 3'd2);
    probe(5'd0, 32'h0);
    run_rtype(5'd1, 5'd2, 5'd3, 3'd2);
    old_val = rf_m[3];
    instr   = {6'h00, 5'd3, 5'd1, 5'd3, 5'd0, 6'h20};
    fetch_word(instr);
    cycle(c_decode());
    cycle(c_exec(2'd0, 3'd2));
    cycle(c_wb(1'b1, 1'b0));
    cycle(c_exec(2'd2, 3'd2));
    exp = old_val + sext16(instr[15:0]);
    apply(c_mem());
    checks++;
    if (mem_addr !== exp) begin
      failures++;
      $display("FAIL same_reg_old_a: got %h expected %h", mem_addr, exp);
    end
    tick();
    rf_m[3] = old_val + rf_m[1];
    probe(5'd3, 32'd13);
  endtask

  task automatic test_alu();
    ctrl_t c;
    do_reset();
    run_addi(5'd4, 16'h1234);
    fetch_word({6'h00, 5'd4, 5'd4, 5'd5, 5'd0, 6'h22});
    cycle(c_decode());
    apply(c_exec(2'd0, 3'd6));
    checks++;
    if (zero !== 1'b1) begin failures++; $display("FAIL zero_sub_equal: got %b expected 1", zero); end
    drive(c_exec(2'd0, 3'd2));
    #1;
    checks++;
    if (zero !== 1'b0) begin failures++; $display("FAIL zero_add_nonzero: got %b expected 0", zero); end
    drive(c_exec(2'd0, 3'd6));
    tick();
    cycle(c_wb(1'b1, 1'b0));
    rf_m[5] = 32'h0;
    run_addi(5'd6, 16'hFFFF);
    run_addi(5'd7, 16'd1);
    run_rtype(5'd6, 5'd7, 5'd8, 3'd7);
    probe(5'd8, 32'd1);
    run_rtype(5'd7, 5'd6, 5'd9, 3'd7);
    probe(5'd9, 32'd0);
    fetch_word({6'h04, 5'd0, 5'd0, 16'hFFFF});
    cycle(c_decode());
    cycle(c_exec(2'd3, 3'd1));
    apply(c_mem());
    checks++;
    if (mem_addr !== 32'hFFFFFFFC) begin
      failures++;
      $display("FAIL imm_shift_operand: got %h expected fffffffc", mem_addr);
    end
    tick();
    cycle(c_exec(2'd2, 3'd1));
    apply(c_mem());
    checks++;
    if (mem_addr !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL imm_sext_operand: got %h expected ffffffff", mem_addr);
    end
    c = '0;
    c.memwrite = 1'b1;
    drive(c);
    #1;
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("FAIL mem_we_pass: got %b expected 1", mem_we); end
    tick();
    probe(5'd4, 32'h1234);
  endtask

  task automatic test_async_reset();
    do_reset();
    run_addi(5'd1, 16'h0010);
    mem[32'h14 >> 2] = 32'hDEADBEEF;
    fetch_word(32'h8C220004);
    cycle(c_decode());
    apply(c_exec(2'd2, 3'd2));
    #2;
    rst = 1'b1;
    IorD = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h0) begin failures++; $display("FAIL async_pc: got %h expected 0", pc); end
    checks++;
    if (opcode !== 6'h0) begin failures++; $display("FAIL async_opcode: got %h expected 0", opcode); end
    checks++;
    if (mem_addr !== 32'h0) begin failures++; $display("FAIL async_aluout: got %h expected 0", mem_addr); end
    @(negedge clk);
    model_reset();
    mem[0] = {6'h08, 5'd0, 5'd5, 16'h0077};
    drive(c_fetch());
    rst = 1'b0;
    tick();
    pc_m = 32'h4;
    checks++;
    if (pc !== 32'h4) begin failures++; $display("FAIL post_reset_fetch_pc: got %h expected 4", pc); end
    checks++;
    if (opcode !== 6'h08) begin failures++; $display("FAIL post_reset_fetch_op: got %h expected 08", opcode); end
    cycle(c_decode());
    cycle(c_exec(2'd2, 3'd2));
    cycle(c_wb(1'b0, 1'b0));
    rf_m[5] = 32'h77;
    probe(5'd5, 32'h77);
    probe(5'd2, 32'h0);
    probe(5'd1, 32'h0);
  endtask

  task automatic test_random();
    int kind;
    logic [4:0] ra, rb, rd;
    logic [2:0] op;
    do_reset();
    for (int i = 1024; i < 1088; i++) mem[i] = $urandom();
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      op = 3'($urandom_range(0, 7));
      if (kind == 0) run_addi(rb, 16'($urandom()));
      else if (kind == 1) run_lw(5'd0, rb, 16'(32'h1000 + 4 * $urandom_range(0, 63)));
      else run_rtype(ra, rb, rd, op);
    end
    for (int r = 0; r < 32; r++) exp_q.push_back(rf_m[r]);
    for (int r = 0; r < 32; r++) probe(5'(r), exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_rtype();
    test_lw();
    test_reg0();
    test_alu();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Datapath half of the multicycle MIPS core: holds PC, IR, MDR, A, B, ALUOut, the 32-entry register file and the ALU. It executes the per-cycle control word issued by `controller` and returns `opcode`, `funct` and `zero` to it. It also drives the unified instruction/data memory port.

## Interface
- `WIDTH`, default 32: data, address and instruction width.
- `RESET_PC`, default 0: PC value after reset.
- `clk`  in  1  clock; all datapath state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PCEn, IorD, Memwrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUsrcA, PCsrc`  in  1 each  control word from `controller`.
- `ALUsrcB`  in  2  ALU B-operand select.
- `ALUControl`  in  3  ALU operation.
- `opcode`  out  6  IR[31:26].
- `funct`  out  6  IR[5:0].
- `zero`  out  1  ALU result == 0 (combinational).
- `mem_addr`  out  WIDTH  memory address.
- `mem_wdata`  out  WIDTH  store data (register B).
- `mem_we`  out  1  equals `Memwrite`.
- `mem_rdata`  in  WIDTH  memory read data, combinational w.r.t. `mem_addr`.
- `pc`  out  WIDTH  current PC, for debug and bench.

## Operation
- Reset: PC=`RESET_PC`; IR, MDR, A, B, ALUOut = 0; all 32 registers = 0.
- `mem_addr` = IorD ? ALUOut : PC.
- IR loads `mem_rdata` when IRWrite=1, else holds.
- MDR, A, B and ALUOut are non-architectural and load every cycle: MDR<=mem_rdata, A<=RF[IR[25:21]], B<=RF[IR[20:16]], ALUOut<=ALU result.
- ALU A operand = ALUsrcA ? A : PC.
- ALU B operand by ALUsrcB: 0 = B; 1 = constant 4; 2 = sign-extended IR[15:0]; 3 = sign-extended IR[15:0] << 2.
- ALUControl: 0 = AND; 1 = OR; 2 = ADD; 6 = SUB; 7 = SLT (signed, result 1 or 0). Codes 3, 4 and 5 produce 0.
- ADD and SUB wrap modulo 2^WIDTH; no overflow flag.
- PC loads when PCEn=1: PCsrc=0 selects the ALU result, PCsrc=1 selects ALUOut.
- Register file write on RegWrite=1:
  - destination = RegDst ? IR[15:11] : IR[20:16];
  - data = MemtoReg ? MDR : ALUOut.
- Register 0 always reads 0; writes to it are discarded.
- Register-file read is combinational. On a read and write of the same index in the same cycle, A/B capture the old value.
- `mem_we` is combinational passthrough of Memwrite; `mem_wdata` = B.
- No internal state machine. Sequencing is wholly owned by `controller`.

## Timing
- `controller` changes the control word on the falling edge of `clk`. The datapath samples on the rising edge, so controls have half a cycle to settle.
- `opcode` and `funct` are valid the cycle after the fetch edge (IRWrite=1). They stay stable until the next IRWrite.
- `zero` is combinational from the current operands and ALUControl; no register.
- Reference instruction latencies, counted from the fetch cycle:
  - R-type: 4 cycles (fetch, decode, execute1, execute2 write-back);
  - lw: 5 cycles (the MDR capture lands at the end of execute2, the register write in execute3).
- Fetch: one edge performs IR<=mem[PC] and PC<=PC+4 together. The IR uses the pre-increment address.
- Reset asserted mid-instruction clears all state immediately, with no waiting for `clk`. The first rising edge after deassertion behaves as fetch from `RESET_PC`.
- Simultaneous PCEn and IRWrite are legal and independent. So are RegWrite and IRWrite: the register write uses the old IR fields.

## Test plan
- Reset, then hold `rst`=1 for 3 edges → pc=0, opcode=0, all register reads 0. Release, drive the fetch word with mem[0]=0x8C220004 (lw $2,4($1)) → IR=0x8C220004, pc=4, opcode=0x23.
- R-type add: RF[1]=5, RF[2]=7, instruction 0x00221820; drive the 4-cycle control sequence → RF[3]=12, pc=4. Repeat with funct 0x22 (sub, 5−7) → RF[3]=0xFFFFFFFE.
- lw: RF[1]=0x10, mem[0x14]=0xDEADBEEF, instruction 0x8C220004; 5-cycle sequence → mem_addr=0x14 in execute2, RF[2]=0xDEADBEEF.
- Register-0 protection: R-type with rd=0, result 9 → RF[0] still reads 0. Simultaneous read and write of register 3 → A captures the old value.
- Zero/ALU: A=B=0x1234 with ALUControl=6 → zero=1. ALUControl=7 with A=−1, B=1 → result 1. ALUsrcB=3 with imm=0xFFFF → operand 0xFFFFFFFC.
- Asynchronous reset between edges in execute1 of lw → pc, IR and ALUOut clear to 0 before the next rising edge. RF[2] stays unwritten.
